// File: rtl/serialize_cyclic.sv
`default_nettype none
// ============================================================================
//  Module      : serialize_cyclic
//  Description : Vector-to-element serializer. Accepts one packed vector of
//                pNUM_OF_ELEMENTS words per handshake and streams the words
//                out one per cycle (odata/odata_en/olast). A shadow buffer
//                holds one further vector so consecutive vectors stream
//                back-to-back without gap cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module serialize_cyclic #(
  parameter int pDATA_IN_W       = 8,
  parameter int pNUM_OF_ELEMENTS = 9
) (
  input  logic                                   iclk,
  input  logic                                   irst,
  input  logic [pDATA_IN_W*pNUM_OF_ELEMENTS-1:0] idata,
  input  logic                                   idata_valid,
  output logic                                   oready,
  input  logic                                   istall,
  output logic [pDATA_IN_W-1:0]                  odata,
  output logic                                   odata_en,
  output logic                                   olast,
  output logic                                   obusy
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (pNUM_OF_ELEMENTS < 1) begin : g_bad_num_elements
    $error("serialize_cyclic: pNUM_OF_ELEMENTS must be >= 1");
  end

  if (pDATA_IN_W < 1) begin : g_bad_data_width
    $error("serialize_cyclic: pDATA_IN_W must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_VEC_W = pDATA_IN_W * pNUM_OF_ELEMENTS;
  // Counter is at least one bit wide so N=1 still has a legal (constant 0) counter.
  localparam int c_CNT_W = (pNUM_OF_ELEMENTS > 1) ? $clog2(pNUM_OF_ELEMENTS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(pNUM_OF_ELEMENTS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_SEND = 1'b1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_VEC_W-1:0]    r_active;
  logic [c_VEC_W-1:0]    r_pending;
  logic                  r_pending_full;
  logic [pDATA_IN_W-1:0] r_odata;
  logic                  r_odata_en;
  logic                  r_olast;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_cnt_last;
  logic                  w_emit;
  logic                  w_emit_last;
  logic                  w_transfer;
  logic                  w_load_active;
  logic                  w_load_pending;
  logic [pDATA_IN_W-1:0] w_elem;

  // The shadow buffer is the only thing that can refuse a vector; the active
  // buffer always has room when the shadow is empty (either idle, or it is
  // refilled no later than the edge its last element leaves).
  assign w_ready     = !r_pending_full && !irst;
  assign w_accept    = idata_valid && w_ready;

  assign w_cnt_last  = (r_cnt == c_CNT_LAST);
  assign w_emit      = (r_state == c_ST_SEND) && !istall;
  assign w_emit_last = w_emit && w_cnt_last;

  // Shadow vector moves into the active slot as the active vector's last
  // element leaves, so the next element 0 follows without a gap.
  assign w_transfer  = w_emit_last && r_pending_full;

  // A new vector goes straight to the active slot when nothing is streaming,
  // or when the active vector finishes on this very edge with no shadow
  // vector waiting; otherwise it is parked in the shadow buffer.
  assign w_load_active  = w_accept &&
                          ((r_state == c_ST_IDLE) || (w_emit_last && !r_pending_full));
  assign w_load_pending = w_accept && !w_load_active;

  // Select the element addressed by the counter (constant-index mux).
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < pNUM_OF_ELEMENTS; k++) begin
      if (r_cnt == c_CNT_W'(k)) begin
        w_elem = r_active[k*pDATA_IN_W +: pDATA_IN_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // FSM and element counter: walk the active vector, chain into the next one.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_state <= c_ST_SEND;
            r_cnt   <= '0;
          end
        end
        c_ST_SEND: begin
          if (w_emit) begin
            if (!w_cnt_last) begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end else if (r_pending_full || w_accept) begin
              // Next vector is already lined up: restart at element 0.
              r_cnt <= '0;
            end else begin
              r_state <= c_ST_IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Active/shadow vector buffers and the shadow occupancy flag.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      if (w_load_active) begin
        r_active <= idata;
      end else if (w_transfer) begin
        r_active <= r_pending;
      end

      // An accept into the shadow and a transfer out of it cannot coincide:
      // a transfer needs the shadow full, which blocks accepts.
      if (w_load_pending) begin
        r_pending      <= idata;
        r_pending_full <= 1'b1;
      end else if (w_transfer) begin
        r_pending_full <= 1'b0;
      end
    end
  end

  // Registered element stream; odata keeps its last value when nothing is sent.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_odata    <= '0;
      r_odata_en <= 1'b0;
      r_olast    <= 1'b0;
    end else if (w_emit) begin
      r_odata    <= w_elem;
      r_odata_en <= 1'b1;
      r_olast    <= w_cnt_last;
    end else begin
      r_odata_en <= 1'b0;
      r_olast    <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oready   = w_ready;
  assign odata    = r_odata;
  assign odata_en = r_odata_en;
  assign olast    = r_olast;
  assign obusy    = (r_state == c_ST_SEND) || r_pending_full;

endmodule
`default_nettype wire

// File: tb/tb_serialize_cyclic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serialize_cyclic
//  Description : Scoreboard bench for serialize_cyclic. Two instances: N=9 and
//                N=1, both W=8. Accepted vectors are flattened into expected
//                element queues; a work-conserving reference (count of unsent
//                elements) predicts odata_en, obusy and oready every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serialize_cyclic;

  localparam int W  = 8;
  localparam int N0 = 9;
  localparam int N1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus
  logic [N0*W-1:0] idata0  = '0;
  logic [N1*W-1:0] idata1  = '0;
  logic            ivalid0 = 1'b0;
  logic            ivalid1 = 1'b0;
  logic [1:0]      stall_man = 2'b00;
  logic [1:0]      stall_rnd = 2'b00;
  logic            rnd_on    = 1'b0;
  logic [1:0]      istall;
  assign istall = stall_man | (rnd_on ? stall_rnd : 2'b00);

  // DUT outputs
  logic         oready0, oready1, oen0, oen1, olast0, olast1, obusy0, obusy1;
  logic [W-1:0] odata0, odata1;

  serialize_cyclic #(.pDATA_IN_W(W), .pNUM_OF_ELEMENTS(N0)) u_dut0 (
    .iclk(clk), .irst(rst), .idata(idata0), .idata_valid(ivalid0), .oready(oready0),
    .istall(istall[0]), .odata(odata0), .odata_en(oen0), .olast(olast0), .obusy(obusy0)
  );

  serialize_cyclic #(.pDATA_IN_W(W), .pNUM_OF_ELEMENTS(N1)) u_dut1 (
    .iclk(clk), .irst(rst), .idata(idata1), .idata_valid(ivalid1), .oready(oready1),
    .istall(istall[1]), .odata(odata1), .odata_en(oen1), .olast(olast1), .obusy(obusy1)
  );

  // Random stall pattern, only applied while rnd_on is set
  always @(negedge clk) begin
    stall_rnd <= {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
  end

  // --------------------------------------------------------------------------
  // Reference model: elements accepted but not yet sent. The block never idles
  // while it holds unsent elements and the downstream is not stalling; it can
  // hold one streaming vector plus one whole shadow vector.
  // --------------------------------------------------------------------------
  int          avail0 = 0, avail1 = 0;
  logic        xen0 = 1'b0, xen1 = 1'b0;
  logic [W:0]  q0[$];
  logic [W:0]  q1[$];

  logic m_acc0, m_acc1, m_emit0, m_emit1;
  assign m_acc0  = ivalid0 && (avail0 <= N0);
  assign m_acc1  = ivalid1 && (avail1 <= N1);
  assign m_emit0 = !istall[0] && (avail0 > 0);
  assign m_emit1 = !istall[1] && (avail1 > 0);

  // Scoreboard push on accept, and next-cycle enable prediction
  always @(posedge clk) begin
    if (rst) begin
      avail0 <= 0; avail1 <= 0; xen0 <= 1'b0; xen1 <= 1'b0;
      q0.delete(); q1.delete();
    end else begin
      xen0   <= m_emit0;
      xen1   <= m_emit1;
      avail0 <= avail0 - (m_emit0 ? 1 : 0) + (m_acc0 ? N0 : 0);
      avail1 <= avail1 - (m_emit1 ? 1 : 0) + (m_acc1 ? N1 : 0);
      if (m_acc0) for (int k = 0; k < N0; k++) q0.push_back({(k == N0 - 1), idata0[k*W +: W]});
      if (m_acc1) for (int k = 0; k < N1; k++) q1.push_back({(k == N1 - 1), idata1[k*W +: W]});
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / checker
  // --------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  int          drv_to   = 0;
  logic        done     = 1'b0;
  logic [W-1:0] last0 = '0, last1 = '0;
  logic [W:0]   e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    while (!done) begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("rst_en0", oen0, 0);      chk("rst_en1", oen1, 0);
        chk("rst_last0", olast0, 0);  chk("rst_last1", olast1, 0);
        chk("rst_busy0", obusy0, 0);  chk("rst_busy1", obusy1, 0);
        chk("rst_ready0", oready0, 0); chk("rst_ready1", oready1, 0);
        chk("rst_data0", odata0, 0);  chk("rst_data1", odata1, 0);
        last0 = '0; last1 = '0;
      end else begin
        chk("en0", oen0, xen0);
        chk("busy0", obusy0, avail0 > 0);
        chk("ready0", oready0, avail0 <= N0);
        if (oen0) begin
          if (q0.size() == 0) chk("unexpected_elem0", oen0, 0);
          else begin
            e = q0.pop_front();
            chk("data0", odata0, e[W-1:0]);
            chk("last0", olast0, e[W]);
          end
          last0 = odata0;
        end else begin
          chk("hold0", odata0, last0);
          chk("idle_last0", olast0, 0);
        end

        chk("en1", oen1, xen1);
        chk("busy1", obusy1, avail1 > 0);
        chk("ready1", oready1, avail1 <= N1);
        if (oen1) begin
          if (q1.size() == 0) chk("unexpected_elem1", oen1, 0);
          else begin
            e = q1.pop_front();
            chk("data1", odata1, e[W-1:0]);
            chk("last1", olast1, e[W]);
          end
          last1 = odata1;
        end else begin
          chk("hold1", odata1, last1);
          chk("idle_last1", olast1, 0);
        end
      end
    end
    chk("driver_timeouts", drv_to, 0);
    chk("drained0", q0.size(), 0);
    chk("drained1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Drivers (operate just after the falling edge)
  // --------------------------------------------------------------------------
  function automatic logic [N0*W-1:0] seqvec(input int base);
    logic [N0*W-1:0] v;
    for (int k = 0; k < N0; k++) v[k*W +: W] = 8'(base + k);
    return v;
  endfunction

  function automatic logic [N0*W-1:0] rndvec();
    logic [N0*W-1:0] v;
    for (int k = 0; k < N0; k++) v[k*W +: W] = 8'($urandom);
    return v;
  endfunction

  // Present a vector and hold it until the rising edge that accepts it
  task automatic offer0(input logic [N0*W-1:0] v);
    logic r;
    int   t;
    t = 0;
    idata0  = v;
    ivalid0 = 1'b1;
    do begin
      r = oready0;
      @(negedge clk);
      t++;
    end while (!r && t < 200);
    if (!r) drv_to++;
  endtask

  task automatic offer1(input logic [N1*W-1:0] v);
    logic r;
    int   t;
    t = 0;
    idata1  = v;
    ivalid1 = 1'b1;
    do begin
      r = oready1;
      @(negedge clk);
      t++;
    end while (!r && t < 200);
    if (!r) drv_to++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Single vector 1..9
    offer0(seqvec(1)); ivalid0 = 1'b0;
    repeat (14) @(negedge clk);

    // Two vectors back-to-back: second goes to the shadow buffer
    offer0(seqvec(1)); offer0(seqvec(10)); ivalid0 = 1'b0;
    repeat (24) @(negedge clk);

    // Stall for 3 cycles while element 4 is next
    offer0(seqvec(1)); ivalid0 = 1'b0;
    repeat (3) @(negedge clk);
    stall_man[0] = 1'b1;
    repeat (3) @(negedge clk);
    stall_man[0] = 1'b0;
    repeat (14) @(negedge clk);

    // Third vector waits while active and shadow are both full
    offer0(seqvec(40)); offer0(seqvec(50)); offer0(seqvec(60)); ivalid0 = 1'b0;
    repeat (34) @(negedge clk);

    // Asynchronous reset after element 5, then a fresh vector 20..28
    offer0(seqvec(1)); ivalid0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    offer0(seqvec(20)); ivalid0 = 1'b0;
    repeat (14) @(negedge clk);

    // N=1: two single-element vectors back-to-back
    offer1(8'hAA); offer1(8'h55); ivalid1 = 1'b0;
    repeat (6) @(negedge clk);

    // Random vectors, random gaps, random stalls on both instances
    rnd_on = 1'b1;
    fork
      begin
        repeat (30) begin
          offer0(rndvec());
          if ($urandom_range(0, 2) == 0) begin
            ivalid0 = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        ivalid0 = 1'b0;
      end
      begin
        repeat (60) begin
          offer1(8'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            ivalid1 = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        ivalid1 = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    rnd_on = 1'b0;
    repeat (40) @(negedge clk);
    done = 1'b1;
  end

endmodule
`default_nettype wire
